// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronized, debounced pushbutton with press/release strobes
//
// Purpose: conditions a raw bouncing pushbutton. The input passes through a
// two-flop synchronizer, then a four-state qualifier FSM that accepts a level
// only after it has held for DEBOUNCE_CYCLES consecutive clocks.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   btn_in       in   raw pushbutton, asynchronous to clk
//   btn_level    out  debounced level, 1 = pressed
//   btn_press    out  one-cycle strobe per accepted press
//   btn_release  out  one-cycle strobe per accepted release
//   press_count  out  accepted presses since reset, modulo 256
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic [7:0] press_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_IDLE            = 2'd0;
  localparam logic [1:0] S_CONFIRM_PRESS   = 2'd1;
  localparam logic [1:0] S_HELD            = 2'd2;
  localparam logic [1:0] S_CONFIRM_RELEASE = 2'd3;

  logic             r_sync1;
  logic             r_btn_s;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic [7:0]       r_press_count;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_press_nxt;
  logic             w_release_nxt;

  // Two-flop synchronizer; only r_btn_s is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_btn_s <= 1'b0;
    end else begin
      r_sync1 <= btn_in;
      r_btn_s <= r_sync1;
    end
  end

  // The counter restarts at 0 on every entry to a confirm state, so any
  // interruption of the candidate level forces a full re-qualification.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_btn_s) begin
          w_state_nxt = S_CONFIRM_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      S_CONFIRM_PRESS: begin
        if (!r_btn_s) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = S_HELD;
          w_cnt_nxt   = '0;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HELD: begin
        if (!r_btn_s) begin
          w_state_nxt = S_CONFIRM_RELEASE;
          w_cnt_nxt   = '0;
        end
      end
      S_CONFIRM_RELEASE: begin
        if (r_btn_s) begin
          w_state_nxt = S_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt   = S_IDLE;
          w_cnt_nxt     = '0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so level, strobe and
  // count all change on the same edge as the accepting transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_level       <= 1'b0;
      r_press       <= 1'b0;
      r_release     <= 1'b0;
      r_press_count <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= (w_state_nxt == S_HELD) || (w_state_nxt == S_CONFIRM_RELEASE);
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      if (w_press_nxt) begin
        r_press_count <= r_press_count + 8'd1;
      end
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign press_count = r_press_count;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic       btn_in;
  logic       btn_level;
  logic       btn_press;
  logic       btn_release;
  logic [7:0] press_count;

  int checks;
  int errors;

  button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .press_count (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n  = 1'b0;
    btn_in = 1'b0;
    #12;
    checks++;
    if (btn_level !== 1'b0) begin
      errors++; $display("FAIL reset_level got %b want 0", btn_level);
    end
    checks++;
    if (btn_press !== 1'b0) begin
      errors++; $display("FAIL reset_press got %b want 0", btn_press);
    end
    checks++;
    if (btn_release !== 1'b0) begin
      errors++; $display("FAIL reset_release got %b want 0", btn_release);
    end
    checks++;
    if (press_count !== 8'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", press_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Edge 1 is the first edge sampling the new level; strobe expected on edge 7.
  task automatic test_press(input string name, input logic [7:0] exp_count);
    @(negedge clk);
    btn_in = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      checks++;
      if (btn_press !== (e == 7)) begin
        errors++; $display("FAIL %s_press edge %0d got %b want %b", name, e, btn_press, (e == 7));
      end
      checks++;
      if (btn_level !== (e >= 7)) begin
        errors++; $display("FAIL %s_level edge %0d got %b want %b", name, e, btn_level, (e >= 7));
      end
      checks++;
      if (btn_release !== 1'b0) begin
        errors++; $display("FAIL %s_no_release edge %0d got %b want 0", name, e, btn_release);
      end
    end
    checks++;
    if (press_count !== exp_count) begin
      errors++; $display("FAIL %s_count got %0d want %0d", name, press_count, exp_count);
    end
  endtask

  task automatic test_release(input string name, input logic [7:0] exp_count);
    @(negedge clk);
    btn_in = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      checks++;
      if (btn_release !== (e == 7)) begin
        errors++; $display("FAIL %s_release edge %0d got %b want %b", name, e, btn_release, (e == 7));
      end
      checks++;
      if (btn_level !== (e < 7)) begin
        errors++; $display("FAIL %s_level edge %0d got %b want %b", name, e, btn_level, (e < 7));
      end
      checks++;
      if (btn_press !== 1'b0) begin
        errors++; $display("FAIL %s_no_press edge %0d got %b want 0", name, e, btn_press);
      end
    end
    checks++;
    if (press_count !== exp_count) begin
      errors++; $display("FAIL %s_count got %0d want %0d", name, press_count, exp_count);
    end
  endtask

  // Three high samples then low: never qualifies with 4-cycle debounce.
  task automatic test_glitch(input logic [7:0] exp_count);
    @(negedge clk);
    btn_in = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (e == 3) btn_in = 1'b0;
      checks++;
      if (btn_level !== 1'b0 || btn_press !== 1'b0 || btn_release !== 1'b0) begin
        errors++;
        $display("FAIL glitch edge %0d got level=%b press=%b release=%b want 0 0 0",
                 e, btn_level, btn_press, btn_release);
      end
    end
    checks++;
    if (press_count !== exp_count) begin
      errors++; $display("FAIL glitch_count got %0d want %0d", press_count, exp_count);
    end
  endtask

  // Samples: edges 1-2 high, 3-4 low, 5-6 high, 7-8 low, 9+ high. Final rising
  // sample on edge 9, so the single strobe lands on edge 15.
  task automatic test_bounce(input logic [7:0] exp_count);
    logic [7:0] pat;
    pat = 8'b0011_0011;
    for (int e = 1; e <= 20; e++) begin
      btn_in = (e <= 8) ? pat[e-1] : 1'b1;
      @(posedge clk); #1;
      checks++;
      if (btn_press !== (e == 15)) begin
        errors++; $display("FAIL bounce_press edge %0d got %b want %b", e, btn_press, (e == 15));
      end
      checks++;
      if (btn_level !== (e >= 15)) begin
        errors++; $display("FAIL bounce_level edge %0d got %b want %b", e, btn_level, (e >= 15));
      end
    end
    checks++;
    if (press_count !== exp_count) begin
      errors++; $display("FAIL bounce_count got %0d want %0d", press_count, exp_count);
    end
  endtask

  task automatic test_reset_mid_hold;
    @(negedge clk);
    btn_in = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (btn_level !== 1'b1) begin
      errors++; $display("FAIL midhold_pre_level got %b want 1", btn_level);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (btn_level !== 1'b0 || btn_press !== 1'b0 || btn_release !== 1'b0 || press_count !== 8'd0) begin
      errors++;
      $display("FAIL midhold_async_reset got level=%b press=%b release=%b count=%0d want 0 0 0 0",
               btn_level, btn_press, btn_release, press_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      checks++;
      if (btn_press !== (e == 7)) begin
        errors++; $display("FAIL midhold_press edge %0d got %b want %b", e, btn_press, (e == 7));
      end
      checks++;
      if (btn_release !== 1'b0) begin
        errors++; $display("FAIL midhold_no_release edge %0d got %b want 0", e, btn_release);
      end
    end
    checks++;
    if (press_count !== 8'd1) begin
      errors++; $display("FAIL midhold_count got %0d want 1", press_count);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_cnt;
    int         n_press;
    int         n_release;
    bit         got;
    @(negedge clk);
    btn_in = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    repeat (2) @(negedge clk);
    exp_cnt   = 8'd0;
    n_press   = 0;
    n_release = 0;
    for (int k = 1; k <= 256; k++) begin
      btn_in = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(posedge clk); #1;
        if (btn_press && btn_release) begin
          checks++; errors++;
          $display("FAIL wrap_both_strobes pair %0d got 1 1 want not both", k);
        end
        if (btn_press) begin
          got = 1'b1;
          n_press++;
          exp_cnt = exp_cnt + 8'd1;
          checks++;
          if (press_count !== exp_cnt) begin
            errors++; $display("FAIL wrap_count pair %0d got %0d want %0d", k, press_count, exp_cnt);
          end
        end
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL wrap_press_timeout pair %0d got none want press", k);
      end
      btn_in = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(posedge clk); #1;
        if (btn_press) begin
          checks++; errors++;
          $display("FAIL wrap_press_without_release pair %0d got 1 want 0", k);
        end
        if (btn_release) begin
          got = 1'b1;
          n_release++;
        end
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL wrap_release_timeout pair %0d got none want release", k);
      end
    end
    checks++;
    if (n_press != 256) begin
      errors++; $display("FAIL wrap_press_pulses got %0d want 256", n_press);
    end
    checks++;
    if (n_release != 256) begin
      errors++; $display("FAIL wrap_release_pulses got %0d want 256", n_release);
    end
    checks++;
    if (press_count !== 8'd0) begin
      errors++; $display("FAIL wrap_final_count got %0d want 0", press_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_press("clean", 8'd1);
    test_release("release", 8'd1);
    test_glitch(8'd1);
    test_bounce(8'd2);
    test_release("bounce_rel", 8'd2);
    test_reset_mid_hold();
    test_release("midhold_rel", 8'd1);
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
